// File: rtl/rgmii_rx_byte_align.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_rx_byte_align
// Purpose  : RGMII receive byte assembler (1000M DDR / 10-100M SDR nibbles),
//            with frame-error flag, max-length truncation and speed tracking.
//            Optional macro INBAND_STATUS_EN: take speed/link from in-band status.
// Revision : 1.0 - initial release
// ============================================================================
module rgmii_rx_byte_align #(
    parameter int P_MAX_LEN       = 1526,
    parameter int P_STATUS_STABLE = 4
) (
    input  logic       i_rxc,
    input  logic       i_rst_n,
    input  logic [7:0] i_iddr_data,
    input  logic [1:0] i_iddr_ctrl,
    input  logic       i_cfg_speed1000,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_end,
    output logic       o_rx_err,
    output logic       o_speed1000,
    output logic       o_link_up
);

    localparam logic [1:0]  c_ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_IDLE      = 2'd1;
    localparam logic [1:0]  c_ST_RECV      = 2'd2;
    localparam logic [1:0]  c_ST_DROP      = 2'd3;
    localparam logic [10:0] c_MAX_LEN      = 11'(P_MAX_LEN);

    logic [1:0]  r_state, w_state_next;
    logic        r_frame_spd, r_phase, r_err;
    logic [10:0] r_cnt;
    logic [3:0]  r_low;
    logic        r_speed, r_link;

    logic        w_dv, w_er, w_in_idle, w_active, w_byte_rdy, w_overflow;
    logic        w_spd, w_phase, w_err_cur;
    logic [10:0] w_cnt_cur;
    logic        w_frame_spd_nxt, w_phase_nxt, w_err_nxt;
    logic [10:0] w_cnt_nxt;
    logic [3:0]  w_low_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_valid_nxt, w_end_nxt, w_rxerr_nxt;

    assign w_dv = i_iddr_ctrl[0];
    assign w_er = i_iddr_ctrl[0] ^ i_iddr_ctrl[1];

    // In IDLE the first DV cycle is processed as byte 0 of a fresh frame.
    assign w_in_idle  = (r_state == c_ST_IDLE);
    assign w_spd      = w_in_idle ? r_speed : r_frame_spd;
    assign w_phase    = w_in_idle ? 1'b0    : r_phase;
    assign w_err_cur  = w_in_idle ? 1'b0    : r_err;
    assign w_cnt_cur  = w_in_idle ? 11'd0   : r_cnt;
    assign w_active   = w_dv && (w_in_idle || (r_state == c_ST_RECV));
    assign w_byte_rdy = w_spd | w_phase;
    assign w_overflow = w_active && w_byte_rdy && (w_cnt_cur == c_MAX_LEN);

    always_ff @(posedge i_rxc) begin
        if (!i_rst_n) begin
            r_state <= c_ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_WAIT_IDLE: if (!w_dv) w_state_next = c_ST_IDLE;
            c_ST_IDLE:      if (w_dv)  w_state_next = w_overflow ? c_ST_DROP : c_ST_RECV;
            c_ST_RECV: begin
                if (!w_dv)           w_state_next = c_ST_IDLE;
                else if (w_overflow) w_state_next = c_ST_DROP;
            end
            c_ST_DROP:      if (!w_dv) w_state_next = c_ST_IDLE;
            default:        w_state_next = c_ST_WAIT_IDLE;
        endcase
    end

    always_comb begin
        w_frame_spd_nxt = w_spd;
        w_phase_nxt     = r_phase;
        w_err_nxt       = r_err;
        w_cnt_nxt       = r_cnt;
        w_low_nxt       = r_low;
        w_data_nxt      = o_rx_data;
        w_valid_nxt     = 1'b0;
        w_end_nxt       = 1'b0;
        w_rxerr_nxt     = 1'b0;
        if (w_active) begin
            w_err_nxt   = w_err_cur | w_er;
            w_phase_nxt = w_spd ? 1'b0 : ~w_phase;
            w_cnt_nxt   = w_cnt_cur;
            if (!w_spd && !w_phase) begin
                w_low_nxt = i_iddr_data[3:0];
            end
            if (w_byte_rdy) begin
                if (w_cnt_cur == c_MAX_LEN) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_spd ? i_iddr_data : {i_iddr_data[3:0], r_low};
                    w_cnt_nxt   = w_cnt_cur + 11'd1;
                end
            end
        end else if ((r_state == c_ST_RECV) && !w_dv) begin
            // A leftover odd nibble in 10/100M is a dribble error.
            w_end_nxt   = 1'b1;
            w_rxerr_nxt = r_err | (~r_frame_spd & r_phase);
        end else if ((r_state == c_ST_DROP) && !w_dv) begin
            w_end_nxt   = 1'b1;
            w_rxerr_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_rxc) begin
        if (!i_rst_n) begin
            r_frame_spd <= 1'b0;
            r_phase     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 11'd0;
            r_low       <= 4'd0;
            o_rx_data   <= 8'd0;
            o_rx_valid  <= 1'b0;
            o_rx_end    <= 1'b0;
            o_rx_err    <= 1'b0;
        end else begin
            r_frame_spd <= w_frame_spd_nxt;
            r_phase     <= w_phase_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_low       <= w_low_nxt;
            o_rx_data   <= w_data_nxt;
            o_rx_valid  <= w_valid_nxt;
            o_rx_end    <= w_end_nxt;
            o_rx_err    <= w_rxerr_nxt;
        end
    end

`ifdef INBAND_STATUS_EN
    localparam int                  c_STAB_W = $clog2(P_STATUS_STABLE + 1);
    localparam logic [c_STAB_W-1:0] c_STABLE = c_STAB_W'(P_STATUS_STABLE);

    logic [1:0]          r_stat_last;
    logic [c_STAB_W-1:0] r_stat_cnt;
    logic                w_stat_sample;
    logic [1:0]          w_stat;
    logic                w_unused_cfg;

    assign w_unused_cfg  = i_cfg_speed1000;
    assign w_stat_sample = (i_iddr_ctrl == 2'b00);
    assign w_stat        = {i_iddr_data[0], (i_iddr_data[2:1] == 2'b10)};

    always_ff @(posedge i_rxc) begin
        if (!i_rst_n) begin
            r_stat_last <= 2'b00;
            r_stat_cnt  <= '0;
            r_speed     <= 1'b0;
            r_link      <= 1'b0;
        end else begin
            if (w_stat_sample) begin
                if (w_stat == r_stat_last) begin
                    if (r_stat_cnt != c_STABLE) r_stat_cnt <= r_stat_cnt + 1'b1;
                end else begin
                    r_stat_last <= w_stat;
                    r_stat_cnt  <= c_STAB_W'(1);
                end
            end
            // Frames in flight keep their speed; only apply between frames.
            if ((r_stat_cnt == c_STABLE) &&
                ((r_state == c_ST_IDLE) || (r_state == c_ST_WAIT_IDLE))) begin
                r_link  <= r_stat_last[1];
                r_speed <= r_stat_last[0];
            end
        end
    end
`else
    always_ff @(posedge i_rxc) begin
        if (!i_rst_n) begin
            r_speed <= i_cfg_speed1000;
            r_link  <= 1'b0;
        end else begin
            r_link <= 1'b1;
            if ((r_state == c_ST_IDLE) || (r_state == c_ST_WAIT_IDLE)) begin
                r_speed <= i_cfg_speed1000;
            end
        end
    end
`endif

    assign o_speed1000 = r_speed;
    assign o_link_up   = r_link;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_rx_byte_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_rx_byte_align
// Purpose  : Randomized self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgmii_rx_byte_align;

    localparam int MAX_LEN = 1526;

    logic       i_rxc = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_iddr_data;
    logic [1:0] i_iddr_ctrl;
    logic       i_cfg_speed1000;
    logic [7:0] o_rx_data;
    logic       o_rx_valid, o_rx_end, o_rx_err, o_speed1000, o_link_up;

    always #5 i_rxc = ~i_rxc;

    rgmii_rx_byte_align #(.P_MAX_LEN(MAX_LEN), .P_STATUS_STABLE(4)) u_dut (
        .i_rxc(i_rxc), .i_rst_n(i_rst_n), .i_iddr_data(i_iddr_data),
        .i_iddr_ctrl(i_iddr_ctrl), .i_cfg_speed1000(i_cfg_speed1000),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_end(o_rx_end),
        .o_rx_err(o_rx_err), .o_speed1000(o_speed1000), .o_link_up(o_link_up)
    );

    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] idle_status = 8'h05;
    bit         cur_spd = 1'b0;

    logic [7:0] q_exp_data[$];  int q_exp_stamp[$];
    int         q_exp_end[$];   bit q_exp_err[$];   bit q_exp_spd[$];
    logic [7:0] q_got_data[$];  int q_got_stamp[$];
    int         q_got_end[$];   bit q_got_err[$];   bit q_got_spd[$];

    always @(posedge i_rxc) cyc++;

    always @(negedge i_rxc) begin
        if (o_rx_valid) begin
            q_got_data.push_back(o_rx_data);
            q_got_stamp.push_back(cyc);
        end
        if (o_rx_end) begin
            q_got_end.push_back(cyc);
            q_got_err.push_back(o_rx_err);
            q_got_spd.push_back(o_speed1000);
        end
        if (o_rx_valid && o_rx_end) begin
            n_fail++;
            $display("FAIL exclusive: valid=%0b end=%0b at cycle %0d, required not both", o_rx_valid, o_rx_end, cyc);
        end
    end

    function automatic logic [7:0] status_for(input bit s);
        return s ? 8'h05 : 8'h03;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_iddr_ctrl = 2'b00;
            i_iddr_data = idle_status;
            @(posedge i_rxc); #1;
        end
    endtask

    task automatic set_speed(input bit s);
        i_cfg_speed1000 = s;
        idle_status     = status_for(s);
        cur_spd         = s;
        idle(8);
        n_vec++;
        if (o_speed1000 !== s) begin
            n_fail++;
            $display("FAIL set_speed: o_speed1000=%0b required %0b", o_speed1000, s);
        end
    endtask

    // Model: bytes emitted = first min(n,MAX_LEN); 1000M byte i out at s0+i,
    // 10/100M byte i out with its high nibble at s0+2i+1; end at first DV=0.
    task automatic drive_frame(input bit spd, input int nbytes, input int er_at,
                               input bit dribble, input bit seq, input int gap,
                               input int flip_at);
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic [3:0] nib;
        bit         er;
        int         s0, ncyc, bi;
        s0 = cyc + 1;
        for (int i = 0; i < nbytes; i++) begin
            b = seq ? 8'(i) : 8'($urandom);
            bytes.push_back(b);
        end
        for (int i = 0; i < nbytes && i < MAX_LEN; i++) begin
            q_exp_data.push_back(bytes[i]);
            q_exp_stamp.push_back(spd ? s0 + i : s0 + 2 * i + 1);
        end
        ncyc = spd ? nbytes : 2 * nbytes + (dribble ? 1 : 0);
        q_exp_end.push_back(s0 + ncyc);
        q_exp_err.push_back((er_at >= 0) || (nbytes > MAX_LEN) || (!spd && dribble));
        q_exp_spd.push_back(spd);
        for (int c = 0; c < ncyc; c++) begin
            if (c == flip_at) begin
                i_cfg_speed1000 = ~i_cfg_speed1000;
                idle_status     = status_for(i_cfg_speed1000);
            end
            if (spd) begin
                i_iddr_data = bytes[c];
                er          = (c == er_at);
            end else begin
                bi = c / 2;
                if (bi < nbytes) begin
                    b   = bytes[bi];
                    nib = (c % 2 == 1) ? b[7:4] : b[3:0];
                end else begin
                    nib = 4'($urandom);
                end
                i_iddr_data = {4'($urandom), nib};
                er          = (c == 2 * er_at);
            end
            i_iddr_ctrl = {~er, 1'b1};
            @(posedge i_rxc); #1;
        end
        idle(gap);
    endtask

    task automatic check_all(input string name);
        int nf;
        idle(2);
        nf = 0;
        n_vec++;
        if (q_got_data.size() != q_exp_data.size()) begin
            n_fail++;
            $display("FAIL %s byte count: got %0d required %0d", name, q_got_data.size(), q_exp_data.size());
        end
        for (int i = 0; i < q_got_data.size() && i < q_exp_data.size(); i++) begin
            n_vec++;
            if (q_got_data[i] !== q_exp_data[i] || q_got_stamp[i] != q_exp_stamp[i]) begin
                n_fail++;
                if (nf++ < 8)
                    $display("FAIL %s byte %0d: got %02h@%0d required %02h@%0d", name, i,
                             q_got_data[i], q_got_stamp[i], q_exp_data[i], q_exp_stamp[i]);
            end
        end
        n_vec++;
        if (q_got_end.size() != q_exp_end.size()) begin
            n_fail++;
            $display("FAIL %s end count: got %0d required %0d", name, q_got_end.size(), q_exp_end.size());
        end
        for (int i = 0; i < q_got_end.size() && i < q_exp_end.size(); i++) begin
            n_vec++;
            if (q_got_end[i] != q_exp_end[i] || q_got_err[i] !== q_exp_err[i] || q_got_spd[i] !== q_exp_spd[i]) begin
                n_fail++;
                $display("FAIL %s end %0d: got cyc=%0d err=%0b spd=%0b required cyc=%0d err=%0b spd=%0b", name, i,
                         q_got_end[i], q_got_err[i], q_got_spd[i], q_exp_end[i], q_exp_err[i], q_exp_spd[i]);
            end
        end
        q_exp_data.delete(); q_exp_stamp.delete(); q_exp_end.delete(); q_exp_err.delete(); q_exp_spd.delete();
        q_got_data.delete(); q_got_stamp.delete(); q_got_end.delete(); q_got_err.delete(); q_got_spd.delete();
    endtask

    task automatic test_reset();
        logic [11:0] got;
        logic [11:0] req;
        i_rst_n = 1'b0;
        i_cfg_speed1000 = 1'b1;
        idle(3);
        got = {o_rx_data, o_rx_valid, o_rx_end, o_rx_err, o_link_up};
        req = 12'h000;
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL reset outputs: got %03h required %03h", got, req);
        end
        n_vec++;
`ifdef INBAND_STATUS_EN
        if (o_speed1000 !== 1'b0) begin
`else
        if (o_speed1000 !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL reset speed: got %0b", o_speed1000);
        end
        i_rst_n = 1'b1;
`ifdef INBAND_STATUS_EN
        idle(8);
`else
        idle(1);
`endif
        n_vec++;
        if (o_link_up !== 1'b1) begin
            n_fail++;
            $display("FAIL link_up after reset: got %0b required 1", o_link_up);
        end
        q_got_end.delete();
    endtask

    task automatic test_gig_64();
        set_speed(1);
        drive_frame(1, 64, -1, 0, 1, 10, -1);
        check_all("gig64");
    endtask

    task automatic test_fast_60();
        set_speed(0);
        drive_frame(0, 60, -1, 0, 1, 10, -1);
        check_all("fast60");
        drive_frame(0, 60, -1, 1, 1, 10, -1);
        check_all("fast60_dribble");
    endtask

    task automatic test_er();
        set_speed(1);
        drive_frame(1, 40, 10, 0, 0, 10, -1);
        check_all("gig_er");
        set_speed(0);
        drive_frame(0, 25, 7, 0, 0, 10, -1);
        check_all("fast_er");
    endtask

    task automatic test_max_len();
        set_speed(1);
        drive_frame(1, 2000, -1, 0, 0, 10, -1);
        check_all("maxlen");
        drive_frame(1, 64, -1, 0, 0, 10, -1);
        check_all("after_maxlen");
        drive_frame(1, MAX_LEN, -1, 0, 0, 10, -1);
        check_all("exact_maxlen");
    endtask

    task automatic test_reset_mid();
        int s0;
        logic [7:0] b;
        set_speed(1);
        s0 = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            q_exp_data.push_back(b);
            q_exp_stamp.push_back(s0 + i);
            i_iddr_data = b;
            i_iddr_ctrl = 2'b11;
            @(posedge i_rxc); #1;
        end
        i_rst_n = 1'b0;
        @(posedge i_rxc); #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_iddr_data = 8'($urandom);
            i_iddr_ctrl = 2'b11;
            @(posedge i_rxc); #1;
        end
        idle(5);
        check_all("reset_mid");
        set_speed(1);
        drive_frame(1, 64, -1, 0, 0, 10, -1);
        check_all("after_reset");
    endtask

    task automatic test_back_to_back();
        set_speed(1);
        drive_frame(1, 20, -1, 0, 0, 1, -1);
        drive_frame(1, 15, -1, 0, 0, 4, -1);
        check_all("b2b_gig");
        set_speed(0);
        drive_frame(0, 12, -1, 0, 0, 1, -1);
        drive_frame(0, 9, -1, 0, 0, 4, -1);
        check_all("b2b_fast");
    endtask

    task automatic test_speed_hold();
        set_speed(1);
        drive_frame(1, 30, -1, 0, 0, 8, 5);
        check_all("speed_hold_gig");
        n_vec++;
        if (o_speed1000 !== 1'b0) begin
            n_fail++;
            $display("FAIL speed after frame: got %0b required 0", o_speed1000);
        end
        cur_spd = 1'b0;
        drive_frame(0, 20, -1, 0, 0, 8, 9);
        check_all("speed_hold_fast");
        n_vec++;
        if (o_speed1000 !== 1'b1) begin
            n_fail++;
            $display("FAIL speed after frame: got %0b required 1", o_speed1000);
        end
        cur_spd = 1'b1;
    endtask

    task automatic test_random();
        bit spd, drib;
        int len, er;
        for (int k = 0; k < 24; k++) begin
            spd = 1'($urandom_range(0, 1));
            if (spd != cur_spd) set_speed(spd);
            len  = $urandom_range(1, 80);
            er   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            drib = !spd && ($urandom_range(0, 3) == 0);
            drive_frame(spd, len, er, drib, 0, $urandom_range(1, 5), -1);
            if (k % 4 == 3) check_all("random");
        end
        check_all("random_tail");
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_iddr_ctrl = 2'b00;
        i_iddr_data = idle_status;
        i_cfg_speed1000 = 1'b0;
        @(posedge i_rxc); #1;
        test_reset();
        test_gig_64();
        test_fast_60();
        test_er();
        test_max_len();
        test_reset_mid();
        test_back_to_back();
        test_speed_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
